// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz VGA raster generator.
// The DEF_* values are the defaults for the standard mode; vga_timing_gen takes
// them as parameter defaults so smaller rasters can be built from the same RTL.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START   = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START   = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC - 1;

    // True when pos lies in the inclusive range [lo, hi].
    function automatic logic inWindow(coord_t pos, coord_t lo, coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis. Counts 0..LAST while en_i is high and
// wraps back to 0; parks at LAST during reset so the first enabled edge after
// release lands on 0. next_o exposes the value the counter takes on the next
// edge so the parent can register decodes aligned with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t LAST = coord_t'(DEF_H_TOTAL - 1)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [9:0] count_o,
    output logic [9:0] next_o,
    output logic       wrap_o
);

    coord_t count_q;
    coord_t count_d;

    // Next count: hold when disabled, otherwise step and wrap at LAST.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
        end
    end

    // Count register, parked at the last position while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;
    assign wrap_o  = en_i && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (640x480@60 Hz by default).
// Every output is registered from the counters' next-state, so all outputs
// describe the pixel currently shown on DrawX/DrawY.
// Optional macro VGA_SYNC_DELAY_EN: delays hs/vs by one extra register stage
// to line up with a one-cycle colour pipeline downstream.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START_C = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END_C   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START_C = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END_C   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Both totals must fit the 10-bit coordinate type.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gBadTotals
        $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    coord_t hCount_q;
    coord_t hCount_d;
    coord_t vCount_q;
    coord_t vCount_d;
    logic   hWrap;
    logic   vWrap;

    logic       blank_q;
    logic       hs_q;
    logic       vs_q;
    logic       lineStart_q;
    logic       frameStart_q;
    logic [7:0] frameCnt_q;

    vga_axis_counter #(
        .LAST (H_LAST)
    ) uHCount (
        .clk_i   (vga_clk),
        .rst_ni  (reset_n),
        .en_i    (1'b1),
        .count_o (hCount_q),
        .next_o  (hCount_d),
        .wrap_o  (hWrap)
    );

    vga_axis_counter #(
        .LAST (V_LAST)
    ) uVCount (
        .clk_i   (vga_clk),
        .rst_ni  (reset_n),
        .en_i    (hWrap),
        .count_o (vCount_q),
        .next_o  (vCount_d),
        .wrap_o  (vWrap)
    );

    // Decode the upcoming position so the registered flags line up with the counters.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q      <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            frameCnt_q   <= 8'd0;
        end else begin
            blank_q      <= (hCount_d < H_VIS_C) && (vCount_d < V_VIS_C);
            hs_q         <= !inWindow(hCount_d, HS_START_C, HS_END_C);
            vs_q         <= !inWindow(vCount_d, VS_START_C, VS_END_C);
            lineStart_q  <= hWrap;
            frameStart_q <= vWrap;
            if (vWrap) begin
                frameCnt_q <= frameCnt_q + 8'd1;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hsDly_q;
    logic vsDly_q;

    // Extra sync stage so hs/vs match the downstream colour latency.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hsDly_q <= 1'b1;
            vsDly_q <= 1'b1;
        end else begin
            hsDly_q <= hs_q;
            vsDly_q <= vs_q;
        end
    end

    assign hs = hsDly_q;
    assign vs = vsDly_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

    assign DrawX       = hCount_q;
    assign DrawY       = vCount_q;
    assign blank       = blank_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;
    assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen. One instance uses the default
// 640x480 timing for reset and line-level checks; a second, shrunken raster
// (25 x 13) makes whole-frame behaviour reachable in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SYNC_LAG = 1;
`else
    localparam int SYNC_LAG = 0;
`endif

    // Shrunken raster: H 16+2+4+3 = 25, V 6+2+2+3 = 13, frame = 325 cycles.
    localparam int S_HT    = 25;
    localparam int S_FRAME = 325;

    logic vga_clk;
    logic reset_n;

    logic [9:0] fDrawX, fDrawY;
    logic       fBlank, fHs, fVs, fLineStart, fFrameStart;
    logic [7:0] fFrameCnt;

    logic [9:0] sDrawX, sDrawY;
    logic       sBlank, sHs, sVs, sLineStart, sFrameStart;
    logic [7:0] sFrameCnt;

    int compareCount;
    int mismatchCount;

    vga_timing_gen dutFull (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (fDrawX),
        .DrawY       (fDrawY),
        .blank       (fBlank),
        .hs          (fHs),
        .vs          (fVs),
        .line_start  (fLineStart),
        .frame_start (fFrameStart),
        .frame_cnt   (fFrameCnt)
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_VISIBLE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dutSmall (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (sDrawX),
        .DrawY       (sDrawY),
        .blank       (sBlank),
        .hs          (sHs),
        .vs          (sVs),
        .line_start  (sLineStart),
        .frame_start (sFrameStart),
        .frame_cnt   (sFrameCnt)
    );

    // 25 MHz-style free-running pixel clock.
    initial begin
        vga_clk = 1'b0;
        forever #20 vga_clk = ~vga_clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Main directed sequence.
    initial begin
        int hsLow, hsFall, hsRise, lineStarts, lineStartAt;
        int vsLow, vsFall, fsCount, fs1, fs2, sLineStarts;

        compareCount  = 0;
        mismatchCount = 0;
        reset_n       = 1'b0;

        // Reset held for 5 cycles: both rasters parked on their last pixel.
        repeat (5) @(negedge vga_clk);
        checkOutput("rst_fullX",     fDrawX, 799);
        checkOutput("rst_fullY",     fDrawY, 524);
        checkOutput("rst_blank",     fBlank, 0);
        checkOutput("rst_hs",        fHs, 1);
        checkOutput("rst_vs",        fVs, 1);
        checkOutput("rst_lineStart", fLineStart, 0);
        checkOutput("rst_frameStart", fFrameStart, 0);
        checkOutput("rst_frameCnt",  fFrameCnt, 0);
        checkOutput("rst_smallX",    sDrawX, 24);
        checkOutput("rst_smallY",    sDrawY, 12);

        // First edge after release wraps to (0,0) and starts frame 1.
        reset_n = 1'b1;
        @(negedge vga_clk);
        checkOutput("first_X",          fDrawX, 0);
        checkOutput("first_Y",          fDrawY, 0);
        checkOutput("first_blank",      fBlank, 1);
        checkOutput("first_lineStart",  fLineStart, 1);
        checkOutput("first_frameStart", fFrameStart, 1);
        checkOutput("first_frameCnt",   fFrameCnt, 1);

        // One full line on the default raster: blank edge, hs window, line_start.
        hsLow = 0; hsFall = -1; hsRise = -1; lineStarts = 0; lineStartAt = -1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge vga_clk);
            if (c == 639) checkOutput("blank_at639", fBlank, 1);
            if (c == 640) begin
                checkOutput("blank_at640", fBlank, 0);
                checkOutput("X_at640",     fDrawX, 640);
                checkOutput("Y_at640",     fDrawY, 0);
            end
            if (fHs == 1'b0) begin
                hsLow++;
                if (hsFall < 0) hsFall = c;
            end else if (hsFall >= 0 && hsRise < 0) begin
                hsRise = c;
            end
            if (fLineStart) begin
                lineStarts++;
                lineStartAt = c;
            end
        end
        checkOutput("hs_lowCycles",   hsLow, 96);
        checkOutput("hs_fallX",       hsFall, 656 + SYNC_LAG);
        checkOutput("hs_riseX",       hsRise, 752 + SYNC_LAG);
        checkOutput("lineStart_count", lineStarts, 1);
        checkOutput("lineStart_at",   lineStartAt, 800);
        checkOutput("line1_X",        fDrawX, 0);
        checkOutput("line1_Y",        fDrawY, 1);

        // Asynchronous reset taken between edges must act immediately.
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_fullX", fDrawX, 799);
        checkOutput("async_fullY", fDrawY, 524);
        checkOutput("async_fullY_line_start", fLineStart, 0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;

        // Two frames of the small raster: frame_start period, vs width, frame_cnt.
        @(negedge vga_clk);
        checkOutput("s_first_X",        sDrawX, 0);
        checkOutput("s_first_Y",        sDrawY, 0);
        checkOutput("s_first_frameCnt", sFrameCnt, 1);
        vsLow = 0; vsFall = -1; fsCount = 0; fs1 = -1; fs2 = -1; sLineStarts = 0;
        for (int c = 1; c <= 2 * S_FRAME; c++) begin
            @(negedge vga_clk);
            if (c == 15)  checkOutput("s_blank_x15",  sBlank, 1);
            if (c == 16)  checkOutput("s_blank_x16",  sBlank, 0);
            if (c == 150) checkOutput("s_blank_y6",   sBlank, 0);
            if (sVs == 1'b0) begin
                vsLow++;
                if (vsFall < 0) vsFall = c;
            end
            if (sLineStart) sLineStarts++;
            if (sFrameStart) begin
                fsCount++;
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
        end
        checkOutput("s_fs_count",      fsCount, 2);
        checkOutput("s_fs_first",      fs1, S_FRAME);
        checkOutput("s_fs_period",     fs2 - fs1, S_FRAME);
        checkOutput("s_vs_lowCycles",  vsLow, 2 * 2 * S_HT);
        checkOutput("s_vs_fall",       vsFall, 8 * S_HT + SYNC_LAG);
        checkOutput("s_lineStarts",    sLineStarts, 26);
        checkOutput("s_frameCnt_3rd",  sFrameCnt, 3);
        checkOutput("s_frameStart_3rd", sFrameStart, 1);

        // Move to (10,4) in frame 3, then reset mid-frame.
        repeat (4 * S_HT + 10) @(negedge vga_clk);
        checkOutput("s_pre_X",     sDrawX, 10);
        checkOutput("s_pre_Y",     sDrawY, 4);
        checkOutput("s_pre_blank", sBlank, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("s_mid_X",        sDrawX, 24);
        checkOutput("s_mid_Y",        sDrawY, 12);
        checkOutput("s_mid_blank",    sBlank, 0);
        checkOutput("s_mid_hs",       sHs, 1);
        checkOutput("s_mid_vs",       sVs, 1);
        checkOutput("s_mid_frameCnt", sFrameCnt, 0);
        checkOutput("f_mid_X",        fDrawX, 799);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        checkOutput("s_restart_X",          sDrawX, 0);
        checkOutput("s_restart_Y",          sDrawY, 0);
        checkOutput("s_restart_frameStart", sFrameStart, 1);
        checkOutput("s_restart_frameCnt",   sFrameCnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
